// File: rtl/cpu_controller.sv
// ----------------------------------------------------------------------------
// cpu_controller
//   Multi-cycle control FSM for the 16-bit Simple RISC Machine. Fetches each
//   instruction, decodes {opcode, op} and sequences the register file / ALU
//   datapath, the PC and the memory port one state per clock. All outputs are
//   Moore outputs. They are computed from the next state and registered
//   alongside it, so they are glitch-free during each state.
//
//   Optional feature: define CPU_CALL_EN to decode opcode 010 (BL, BX, BLX).
//   Without it, opcode 010 halts and the call states are not built.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode, op, cond      instruction fields [15:13], [12:11], [10:8]
//   N, V, Z               registered status flags from the datapath
//   nsel                  one-hot register select: 001 Rn, 010 Rd, 100 Rm
//   write, load[abcsm]    datapath strobes
//   asel, bsel, csel      datapath operand muxes
//   vsel                  one-hot writeback: 0001 C, 0010 mdata, 0100 sximm8, 1000 PC
//   load_pc, reset_pc     PC register controls
//   pc_sel                PC source: 00 PC+1, 01 PC+1+sximm8, 10 datapath_out
//   addr_sel              memory address source: 1 PC, 0 data_address
//   load_ir               instruction register load
//   mem_cmd               00 none, 01 read, 10 write
//   halted                high while in HALT
//   state_dbg             current FSM state encoding, for observation only
// ----------------------------------------------------------------------------
module cpu_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output logic [2:0] nsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       loadm,
    output logic       asel,
    output logic       bsel,
    output logic       csel,
    output logic [3:0] vsel,
    output logic       load_pc,
    output logic       reset_pc,
    output logic [1:0] pc_sel,
    output logic       addr_sel,
    output logic       load_ir,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic [4:0] state_dbg
);

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_MDATA = 4'b0010;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b1000;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_REL  = 2'b01;
    localparam logic [1:0] PC_DOUT = 2'b10;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST       = 5'd0,
        S_IF1       = 5'd1,
        S_IF2       = 5'd2,
        S_UPDATE_PC = 5'd3,
        S_DECODE    = 5'd4,
        S_WRITE_IMM = 5'd5,
        S_GET_A     = 5'd6,
        S_GET_B     = 5'd7,
        S_EXEC      = 5'd8,
        S_WRITE_REG = 5'd9,
        S_MEM_ADDR  = 5'd10,
        S_MEM_RD    = 5'd11,
        S_LDR_WB    = 5'd12,
        S_STR_GETD  = 5'd13,
        S_STR_C     = 5'd14,
        S_MEM_WR    = 5'd15,
        S_BRANCH    = 5'd16,
        S_HALT      = 5'd17
`ifdef CPU_CALL_EN
        ,
        S_BL_LINK      = 5'd18,
        S_BRANCH_TAKEN = 5'd19,
        S_BX_GET       = 5'd20,
        S_BX_C         = 5'd21,
        S_BX_PC        = 5'd22
`endif
    } state_t;

    typedef struct packed {
        logic [2:0] nsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       loadm;
        logic       asel;
        logic       bsel;
        logic       csel;
        logic [3:0] vsel;
        logic       load_pc;
        logic       reset_pc;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic       load_ir;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    logic is_cmp;
    logic is_ldr;
    logic branch_taken;

    assign is_cmp = (opcode == 3'b101) && (op == 2'b01);
    assign is_ldr = (opcode == 3'b011);

    // Flags only change in a CMP's EXEC, so their value on entry to BRANCH
    // is the value held throughout BRANCH.
    always_comb begin
        branch_taken = 1'b0;
        case (cond)
            3'b000:  branch_taken = 1'b1;
            3'b001:  branch_taken = Z;
            3'b010:  branch_taken = ~Z;
            3'b011:  branch_taken = N ^ V;
            3'b100:  branch_taken = (N ^ V) | Z;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state logic. GET_A, GET_B, EXEC and MEM_ADDR are shared between
    // instructions; the opcode (stable in the IR) picks the successor.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:       state_d = S_IF1;
            S_IF1:       state_d = S_IF2;
            S_IF2:       state_d = S_UPDATE_PC;
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                case ({opcode, op})
                    5'b110_10: state_d = S_WRITE_IMM;
                    5'b110_00: state_d = S_GET_B;
                    5'b101_00,
                    5'b101_01,
                    5'b101_10: state_d = S_GET_A;
                    5'b101_11: state_d = S_GET_B;
                    5'b011_00,
                    5'b100_00: state_d = S_GET_A;
                    5'b001_00: state_d = S_BRANCH;
`ifdef CPU_CALL_EN
                    5'b010_11,
                    5'b010_10: state_d = S_BL_LINK;
                    5'b010_00: state_d = S_BX_GET;
`endif
                    default:   state_d = S_HALT;
                endcase
            end
            S_WRITE_IMM: state_d = S_IF1;
            S_GET_A:     state_d = (opcode == 3'b101) ? S_GET_B : S_MEM_ADDR;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = is_cmp ? S_IF1 : S_WRITE_REG;
            S_WRITE_REG: state_d = S_IF1;
            S_MEM_ADDR:  state_d = is_ldr ? S_MEM_RD : S_STR_GETD;
            S_MEM_RD:    state_d = S_LDR_WB;
            S_LDR_WB:    state_d = S_IF1;
            S_STR_GETD:  state_d = S_STR_C;
            S_STR_C:     state_d = S_MEM_WR;
            S_MEM_WR:    state_d = S_IF1;
            S_BRANCH:    state_d = S_IF1;
            S_HALT:      state_d = S_HALT;
`ifdef CPU_CALL_EN
            // BL finishes with a relative jump; BLX continues into the BX path.
            S_BL_LINK:      state_d = (op == 2'b11) ? S_BRANCH_TAKEN : S_BX_GET;
            S_BRANCH_TAKEN: state_d = S_IF1;
            S_BX_GET:       state_d = S_BX_C;
            S_BX_C:         state_d = S_BX_PC;
            S_BX_PC:        state_d = S_IF1;
`endif
            default:     state_d = S_RST;
        endcase
    end

    // Moore outputs of the state being entered.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_RST: begin
                ctrl_d.reset_pc = 1'b1;
                ctrl_d.load_pc  = 1'b1;
            end
            S_IF1: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_cmd  = CMD_READ;
            end
            S_IF2: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_cmd  = CMD_READ;
                ctrl_d.load_ir  = 1'b1;
            end
            S_UPDATE_PC: begin
                ctrl_d.load_pc = 1'b1;
                ctrl_d.pc_sel  = PC_INC;
            end
            S_WRITE_IMM: begin
                ctrl_d.nsel  = NSEL_RN;
                ctrl_d.vsel  = VSEL_IMM;
                ctrl_d.write = 1'b1;
            end
            S_GET_A: begin
                ctrl_d.nsel  = NSEL_RN;
                ctrl_d.loada = 1'b1;
            end
            S_GET_B: begin
                ctrl_d.nsel  = NSEL_RM;
                ctrl_d.loadb = 1'b1;
            end
            S_EXEC: begin
                // MOV reg passes B through by zeroing the A operand.
                ctrl_d.asel  = (opcode == 3'b110);
                ctrl_d.loads = is_cmp;
                ctrl_d.loadc = ~is_cmp;
            end
            S_WRITE_REG: begin
                ctrl_d.nsel  = NSEL_RD;
                ctrl_d.vsel  = VSEL_C;
                ctrl_d.write = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_d.bsel  = 1'b1;
                ctrl_d.loadm = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_d.mem_cmd = CMD_READ;
            end
            S_LDR_WB: begin
                ctrl_d.mem_cmd = CMD_READ;
                ctrl_d.nsel    = NSEL_RD;
                ctrl_d.vsel    = VSEL_MDATA;
                ctrl_d.write   = 1'b1;
            end
            S_STR_GETD: begin
                ctrl_d.nsel  = NSEL_RD;
                ctrl_d.loadb = 1'b1;
            end
            S_STR_C: begin
                ctrl_d.asel  = 1'b1;
                ctrl_d.csel  = 1'b1;
                ctrl_d.loadc = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.mem_cmd = CMD_WRITE;
            end
            S_BRANCH: begin
                ctrl_d.load_pc = branch_taken;
                ctrl_d.pc_sel  = branch_taken ? PC_REL : PC_INC;
            end
            S_HALT: begin
                ctrl_d.halted = 1'b1;
            end
`ifdef CPU_CALL_EN
            S_BL_LINK: begin
                ctrl_d.nsel  = NSEL_RN;
                ctrl_d.vsel  = VSEL_PC;
                ctrl_d.write = 1'b1;
            end
            S_BRANCH_TAKEN: begin
                ctrl_d.load_pc = 1'b1;
                ctrl_d.pc_sel  = PC_REL;
            end
            S_BX_GET: begin
                ctrl_d.nsel  = NSEL_RD;
                ctrl_d.loadb = 1'b1;
            end
            S_BX_C: begin
                ctrl_d.asel  = 1'b1;
                ctrl_d.csel  = 1'b1;
                ctrl_d.loadc = 1'b1;
            end
            S_BX_PC: begin
                ctrl_d.load_pc = 1'b1;
                ctrl_d.pc_sel  = PC_DOUT;
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_RST;
            ctrl_q           <= '0;
            ctrl_q.reset_pc  <= 1'b1;
            ctrl_q.load_pc   <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign nsel      = ctrl_q.nsel;
    assign write     = ctrl_q.write;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign loadm     = ctrl_q.loadm;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign csel      = ctrl_q.csel;
    assign vsel      = ctrl_q.vsel;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign pc_sel    = ctrl_q.pc_sel;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_ir   = ctrl_q.load_ir;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign halted    = ctrl_q.halted;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// ----------------------------------------------------------------------------
// tb_cpu_controller
//   Drives cpu_controller with a small behavioural SRM datapath, PC and
//   memory so that programs can run end to end. Each scenario task loads a
//   directed program and compares strobes, cycle counts, registers and PC
//   against hand-computed values.
// ----------------------------------------------------------------------------
module tb_cpu_controller;

    localparam logic [4:0] S_RST       = 5'd0;
    localparam logic [4:0] S_IF1       = 5'd1;
    localparam logic [4:0] S_IF2       = 5'd2;
    localparam logic [4:0] S_UPDATE_PC = 5'd3;
    localparam logic [4:0] S_DECODE    = 5'd4;
    localparam logic [4:0] S_WRITE_IMM = 5'd5;
    localparam logic [4:0] S_GET_B     = 5'd7;
    localparam logic [4:0] S_BRANCH    = 5'd16;
    localparam logic [4:0] S_HALT      = 5'd17;
    localparam logic [15:0] I_HALT     = 16'hE000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_en = 1'b0;

    logic [2:0] opcode, cond, nsel;
    logic [1:0] op, pc_sel, mem_cmd;
    logic       N, V, Z;
    logic       write, loada, loadb, loadc, loads, loadm, asel, bsel, csel;
    logic [3:0] vsel;
    logic       load_pc, reset_pc, addr_sel, load_ir, halted;
    logic [4:0] state_dbg;

    cpu_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .N(N), .V(V), .Z(Z), .nsel(nsel), .write(write), .loada(loada),
        .loadb(loadb), .loadc(loadc), .loads(loads), .loadm(loadm),
        .asel(asel), .bsel(bsel), .csel(csel), .vsel(vsel),
        .load_pc(load_pc), .reset_pc(reset_pc), .pc_sel(pc_sel),
        .addr_sel(addr_sel), .load_ir(load_ir), .mem_cmd(mem_cmd),
        .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural datapath / memory ----------------
    logic [15:0] prog [0:63];
    logic [15:0] mem  [0:63];
    logic [15:0] regs [0:7];
    logic [15:0] ir, pc, a_q, b_q, c_q, mdata, daddr;
    logic        fn, fv, fz;
    logic [2:0]  rsel;
    logic [15:0] sximm8, sximm5, ain, bin, alu, wb, maddr;
    logic        ovf;
    logic [24:0] outs;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign cond   = ir[10:8];
    assign N = fn;
    assign V = fv;
    assign Z = fz;

    always_comb begin
        rsel = 3'd0;
        case (nsel)
            3'b001:  rsel = ir[10:8];
            3'b010:  rsel = ir[7:5];
            3'b100:  rsel = ir[2:0];
            default: rsel = 3'd0;
        endcase
        sximm8 = {{8{ir[7]}}, ir[7:0]};
        sximm5 = {{11{ir[4]}}, ir[4:0]};
        ain = asel ? 16'd0 : a_q;
        bin = bsel ? sximm5 : b_q;
        alu = 16'd0;
        ovf = 1'b0;
        case (ir[12:11])
            2'b00: begin
                alu = ain + bin;
                ovf = (ain[15] == bin[15]) && (alu[15] != ain[15]);
            end
            2'b01: begin
                alu = ain - bin;
                ovf = (ain[15] != bin[15]) && (alu[15] != ain[15]);
            end
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
        wb = 16'd0;
        case (vsel)
            4'b0001: wb = c_q;
            4'b0010: wb = mdata;
            4'b0100: wb = sximm8;
            4'b1000: wb = pc;
            default: wb = 16'd0;
        endcase
        maddr = addr_sel ? pc : daddr;
        outs = {nsel, write, loada, loadb, loadc, loads, loadm, asel, bsel, csel,
                vsel, load_pc, reset_pc, pc_sel, addr_sel, load_ir, mem_cmd, halted};
    end

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= prog[i];
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
            {fn, fv, fz} <= 3'b000;
            ir <= 16'd0; pc <= 16'd0; a_q <= 16'd0; b_q <= 16'd0;
            c_q <= 16'd0; mdata <= 16'd0; daddr <= 16'd0;
        end else begin
            if (write) regs[rsel] <= wb;
            if (loada) a_q <= regs[rsel];
            if (loadb) b_q <= regs[rsel];
            if (loadc) c_q <= csel ? bin : alu;
            if (loads) begin
                fn <= alu[15];
                fv <= ovf;
                fz <= (alu == 16'd0);
            end
            if (loadm) daddr <= alu;
            if (mem_cmd == 2'b01) mdata <= mem[maddr[5:0]];
            if (mem_cmd == 2'b10) mem[maddr[5:0]] <= c_q;
            if (load_ir) ir <= mdata;
            if (load_pc) begin
                if (reset_pc)            pc <= 16'd0;
                else if (pc_sel == 2'b01) pc <= pc + sximm8;
                else if (pc_sel == 2'b10) pc <= c_q;
                else                      pc <= pc + 16'd1;
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int n_assert = 0;
    int n_fail = 0;
    int cyc, n_la, n_lb, n_lc, n_ls, n_wr, n_mw, t_la, t_lb, t_lc;
    logic [2:0]  wr_nsel;
    logic [3:0]  wr_vsel;
    logic [15:0] mw_addr;
    logic        br_lp;
    logic [1:0]  br_ps;

    function automatic logic [15:0] i_movi(input logic [2:0] rn, input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction
    function automatic logic [15:0] i_alu(input logic [1:0] o, input logic [2:0] rn,
                                          input logic [2:0] rd, input logic [2:0] rm);
        return {3'b101, o, rn, rd, 2'b00, rm};
    endfunction
    function automatic logic [15:0] i_mem(input logic [2:0] opc, input logic [2:0] rn,
                                          input logic [2:0] rd, input logic [4:0] imm5);
        return {opc, 2'b00, rn, rd, imm5};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = I_HALT;
    endtask

    // Loads the program, holds reset one cycle (RST), leaves the FSM in IF1.
    task automatic start();
        reset = 1'b1;
        load_en = 1'b1;
        step();
        load_en = 1'b0;
        reset = 1'b0;
        step();
    endtask

    // Runs from one IF1 to the next, recording strobe activity. cyc = -1 on timeout.
    task automatic run_instr();
        cyc = 0; n_la = 0; n_lb = 0; n_lc = 0; n_ls = 0; n_wr = 0; n_mw = 0;
        t_la = -1; t_lb = -1; t_lc = -1;
        wr_nsel = 3'd0; wr_vsel = 4'd0; mw_addr = 16'hFFFF; br_lp = 1'b0; br_ps = 2'b11;
        do begin
            step();
            cyc++;
            if (loada) begin n_la++; if (t_la < 0) t_la = cyc; end
            if (loadb) begin n_lb++; if (t_lb < 0) t_lb = cyc; end
            if (loadc) begin n_lc++; if (t_lc < 0) t_lc = cyc; end
            if (loads) n_ls++;
            if (write) begin n_wr++; wr_nsel = nsel; wr_vsel = vsel; end
            if (mem_cmd == 2'b10 && !addr_sel) begin n_mw++; mw_addr = maddr; end
            if (state_dbg == S_BRANCH) begin br_lp = load_pc; br_ps = pc_sel; end
        end while (state_dbg != S_IF1 && cyc < 40);
        if (state_dbg != S_IF1) cyc = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_prog();
        prog[0] = i_movi(3'd0, 8'd7);
        reset = 1'b1;
        load_en = 1'b1;
        step();
        load_en = 1'b0;
        n_assert++;
        if (state_dbg !== S_RST) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_RST); end
        n_assert++;
        if (outs !== 25'h0000180) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", outs, 25'h0000180); end
        reset = 1'b0;
        step();
        n_assert++;
        if (state_dbg !== S_IF1) begin n_fail++; $display("FAIL first_if1: got %0d expected %0d", state_dbg, S_IF1); end
        n_assert++;
        if (outs !== 25'h0000012) begin n_fail++; $display("FAIL if1_outputs: got %h expected %h", outs, 25'h0000012); end
    endtask

    task automatic test_mov_imm();
        logic [4:0] exp_seq [5];
        int writes;
        exp_seq = '{S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM, S_IF1};
        writes = 0;
        clear_prog();
        prog[0] = i_movi(3'd0, 8'd7);
        start();
        for (int i = 0; i < 5; i++) begin
            step();
            if (write && vsel == 4'b0100) writes++;
            n_assert++;
            if (state_dbg !== exp_seq[i]) begin n_fail++; $display("FAIL mov_imm_seq[%0d]: got %0d expected %0d", i, state_dbg, exp_seq[i]); end
        end
        n_assert++;
        if (writes !== 1) begin n_fail++; $display("FAIL mov_imm_writes: got %0d expected 1", writes); end
        n_assert++;
        if (regs[0] !== 16'd7) begin n_fail++; $display("FAIL mov_imm_r0: got %0d expected 7", regs[0]); end
    endtask

    task automatic test_add();
        clear_prog();
        prog[0] = i_movi(3'd1, 8'd3);
        prog[1] = i_movi(3'd2, 8'd5);
        prog[2] = i_alu(2'b00, 3'd1, 3'd3, 3'd2);
        start();
        run_instr();
        run_instr();
        run_instr();
        n_assert++;
        if (cyc !== 8) begin n_fail++; $display("FAIL add_cycles: got %0d expected 8", cyc); end
        n_assert++;
        if ({n_la, n_lb, n_lc} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL add_load_counts: got %0d/%0d/%0d expected 1/1/1", n_la, n_lb, n_lc);
        end
        n_assert++;
        if ({t_la, t_lb, t_lc} !== {32'd4, 32'd5, 32'd6}) begin
            n_fail++; $display("FAIL add_load_order: got %0d/%0d/%0d expected 4/5/6", t_la, t_lb, t_lc);
        end
        n_assert++;
        if ({wr_nsel, wr_vsel} !== {3'b010, 4'b0001}) begin
            n_fail++; $display("FAIL add_wb_sel: got nsel %b vsel %b expected 010 0001", wr_nsel, wr_vsel);
        end
        n_assert++;
        if (regs[3] !== 16'd8) begin n_fail++; $display("FAIL add_r3: got %0d expected 8", regs[3]); end
    endtask

    // CMP R1,R2 then B<cond> +2 at PC 3 for cond 0..5; taken_mask[c] is the
    // hand-computed outcome for the given operands.
    task automatic test_branch(input logic [7:0] a, input logic [7:0] b, input logic [5:0] taken_mask);
        logic [15:0] exp_pc;
        for (int c = 0; c < 6; c++) begin
            clear_prog();
            prog[0] = i_movi(3'd1, a);
            prog[1] = i_movi(3'd2, b);
            prog[2] = i_alu(2'b01, 3'd1, 3'd0, 3'd2);
            prog[3] = {3'b001, 2'b00, 3'(c), 8'd2};
            start();
            run_instr();
            run_instr();
            run_instr();
            n_assert++;
            if ({cyc, n_ls, n_lc, n_wr} !== {32'd7, 32'd1, 32'd0, 32'd0}) begin
                n_fail++; $display("FAIL cmp_cond%0d: got cyc %0d loads %0d loadc %0d write %0d expected 7 1 0 0", c, cyc, n_ls, n_lc, n_wr);
            end
            run_instr();
            exp_pc = taken_mask[c] ? 16'd6 : 16'd4;
            n_assert++;
            if (cyc !== 5) begin n_fail++; $display("FAIL branch_cycles_cond%0d: got %0d expected 5", c, cyc); end
            n_assert++;
            if (br_lp !== taken_mask[c]) begin n_fail++; $display("FAIL branch_load_pc_cond%0d: got %b expected %b", c, br_lp, taken_mask[c]); end
            if (taken_mask[c]) begin
                n_assert++;
                if (br_ps !== 2'b01) begin n_fail++; $display("FAIL branch_pc_sel_cond%0d: got %b expected 01", c, br_ps); end
            end
            n_assert++;
            if ({addr_sel, pc} !== {1'b1, exp_pc}) begin
                n_fail++; $display("FAIL branch_fetch_cond%0d: got addr_sel %b pc %0d expected 1 %0d", c, addr_sel, pc, exp_pc);
            end
        end
    endtask

    task automatic test_str_ldr();
        clear_prog();
        prog[0] = i_movi(3'd0, 8'd7);
        prog[1] = i_movi(3'd1, 8'd4);
        prog[2] = i_mem(3'b100, 3'd1, 3'd0, 5'd1);
        prog[3] = i_mem(3'b011, 3'd1, 3'd2, 5'd1);
        start();
        run_instr();
        run_instr();
        run_instr();
        n_assert++;
        if ({cyc, n_mw, n_wr} !== {32'd9, 32'd1, 32'd0}) begin
            n_fail++; $display("FAIL str_cycles: got cyc %0d memwr %0d write %0d expected 9 1 0", cyc, n_mw, n_wr);
        end
        n_assert++;
        if (mw_addr !== 16'd5) begin n_fail++; $display("FAIL str_addr: got %0d expected 5", mw_addr); end
        n_assert++;
        if (mem[5] !== 16'd7) begin n_fail++; $display("FAIL str_data: got %0d expected 7", mem[5]); end
        run_instr();
        n_assert++;
        if ({cyc, wr_nsel, wr_vsel} !== {32'd8, 3'b010, 4'b0010}) begin
            n_fail++; $display("FAIL ldr_cycles: got cyc %0d nsel %b vsel %b expected 8 010 0010", cyc, wr_nsel, wr_vsel);
        end
        n_assert++;
        if (regs[2] !== 16'd7) begin n_fail++; $display("FAIL ldr_r2: got %0d expected 7", regs[2]); end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_prog();
        prog[0] = i_movi(3'd1, 8'd3);
        prog[1] = i_movi(3'd2, 8'd5);
        prog[2] = i_alu(2'b00, 3'd1, 3'd3, 3'd2);
        start();
        run_instr();
        run_instr();
        k = 0;
        while (state_dbg != S_GET_B && k < 10) begin step(); k++; end
        n_assert++;
        if (state_dbg !== S_GET_B) begin n_fail++; $display("FAIL mid_reach_getb: got %0d expected %0d", state_dbg, S_GET_B); end
        reset = 1'b1;
        step();
        n_assert++;
        if (state_dbg !== S_RST) begin n_fail++; $display("FAIL mid_reset_state: got %0d expected %0d", state_dbg, S_RST); end
        reset = 1'b0;
        step();
        n_assert++;
        if ({state_dbg, pc, regs[3]} !== {S_IF1, 16'd0, 16'd0}) begin
            n_fail++; $display("FAIL mid_restart: got state %0d pc %0d r3 %0d expected 1 0 0", state_dbg, pc, regs[3]);
        end
    endtask

    task automatic test_halt();
        int hcnt;
        // opcode 000 and an undefined branch op both reach HALT right after DECODE
        for (int t = 0; t < 2; t++) begin
            clear_prog();
            prog[0] = (t == 0) ? 16'h0000 : {3'b001, 2'b01, 11'd0};
            start();
            for (int i = 0; i < 4; i++) step();
            n_assert++;
            if ({state_dbg, halted} !== {S_HALT, 1'b1}) begin
                n_fail++; $display("FAIL halt_entry%0d: got state %0d halted %b expected 17 1", t, state_dbg, halted);
            end
        end
        hcnt = 0;
        for (int i = 0; i < 20; i++) begin step(); if (halted) hcnt++; end
        n_assert++;
        if (hcnt !== 20) begin n_fail++; $display("FAIL halt_hold: got %0d expected 20", hcnt); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_assert++;
        if ({state_dbg, halted} !== {S_RST, 1'b0}) begin
            n_fail++; $display("FAIL halt_reset: got state %0d halted %b expected 0 0", state_dbg, halted);
        end
    endtask

    task automatic test_call();
        clear_prog();
`ifdef CPU_CALL_EN
        prog[0] = i_movi(3'd0, 8'd1);
        prog[1] = i_movi(3'd1, 8'd2);
        prog[2] = {3'b010, 2'b11, 3'd7, 8'd3};
        prog[6] = {3'b010, 2'b00, 3'd0, 3'd7, 5'd0};
        start();
        run_instr();
        run_instr();
        run_instr();
        n_assert++;
        if ({cyc, regs[7], pc} !== {32'd6, 16'd3, 16'd6}) begin
            n_fail++; $display("FAIL bl: got cyc %0d r7 %0d pc %0d expected 6 3 6", cyc, regs[7], pc);
        end
        run_instr();
        n_assert++;
        if ({cyc, pc} !== {32'd7, 16'd3}) begin
            n_fail++; $display("FAIL bx: got cyc %0d pc %0d expected 7 3", cyc, pc);
        end
`else
        prog[0] = {3'b010, 2'b11, 3'd7, 8'd3};
        start();
        for (int i = 0; i < 4; i++) step();
        n_assert++;
        if ({state_dbg, halted} !== {S_HALT, 1'b1}) begin
            n_fail++; $display("FAIL bl_disabled: got state %0d halted %b expected 17 1", state_dbg, halted);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_add();
        test_branch(8'd3, 8'd3, 6'b010011);
        test_branch(8'd3, 8'd5, 6'b011101);
        test_str_ldr();
        test_reset_mid();
        test_halt();
        test_call();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control FSM for the 16-bit Simple RISC Machine CPU. It fetches each instruction, decodes its opcode and op fields, and sequences the register-file/ALU datapath, the program counter and the memory port one state per clock. It sits between the instruction register and decoder on one side and the datapath, PC logic and memory command bus on the other. It is the only source of datapath load and write strobes.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; the FSM enters RST on the next edge.
- opcode  in  3  instruction bits [15:13], from the instruction register.
- op  in  2  instruction bits [12:11].
- cond  in  3  instruction bits [10:8]; the branch condition.
- N, V, Z  in  1 each  registered status flags from the datapath.
- nsel  out  3  one-hot register-field select to the decoder: 001 = Rn, 010 = Rd, 100 = Rm.
- write, loada, loadb, loadc, loads, loadm  out  1 each  datapath strobes.
- asel, bsel, csel  out  1 each  datapath operand muxes.
- vsel  out  4  one-hot writeback select: 0001 = C, 0010 = mdata, 0100 = sximm8, 1000 = PC.
- load_pc, reset_pc  out  1 each  PC register controls.
- pc_sel  out  2  PC source: 00 = PC+1, 01 = PC+1+sximm8, 10 = datapath_out.
- addr_sel  out  1  memory address source: 1 = PC, 0 = data_address.
- load_ir  out  1  instruction register load.
- mem_cmd  out  2  memory command: 00 = none, 01 = read, 10 = write.
- halted  out  1  high while in HALT.

## Operation
Outputs are Moore. Every output not listed for a state is 0, and vsel is 0000.

Fetch sequence, common to all instructions:
- RST: reset_pc = 1, load_pc = 1. Next state IF1.
- IF1: addr_sel = 1, mem_cmd = read.
- IF2: addr_sel = 1, mem_cmd = read, load_ir = 1.
- UPDATE_PC: load_pc = 1, pc_sel = 00.
- DECODE: no outputs asserted; branches on {opcode, op}.

Per-instruction paths (each returns to IF1):
- MOV imm (110/10): WRITE_IMM with nsel = Rn, vsel = 0100, write = 1.
- MOV reg (110/00): GET_B (nsel = Rm, loadb), then EXEC (asel = 1, loadc), then WRITE_REG (nsel = Rd, vsel = 0001, write).
- ADD and AND (101/00, 101/10): GET_A (nsel = Rn, loada), then GET_B, then EXEC (loadc), then WRITE_REG.
- CMP (101/01): GET_A, then GET_B, then EXEC with loads = 1 and loadc = 0. No WRITE_REG.
- MVN (101/11): GET_B, then EXEC (loadc), then WRITE_REG.
- LDR (011/00):
  - GET_A.
  - MEM_ADDR (bsel = 1, loadm).
  - MEM_RD (addr_sel = 0, mem_cmd = read).
  - LDR_WB (addr_sel = 0, mem_cmd = read, nsel = Rd, vsel = 0010, write).
- STR (100/00):
  - GET_A, then MEM_ADDR.
  - STR_GETD (nsel = Rd, loadb).
  - STR_C (asel = 1, csel = 1, loadc).
  - MEM_WR (addr_sel = 0, mem_cmd = write).
- Branch (001/00): BRANCH state. When the condition holds, load_pc = 1 and pc_sel = 01. Conditions:
  - cond 000 B: always taken.
  - cond 001 BEQ: taken when Z.
  - cond 010 BNE: taken when !Z.
  - cond 011 BLT: taken when N≠V.
  - cond 100 BLE: taken when (N≠V) or Z.
  - Any other cond is treated as not taken.
- HALT (111/xx): HALT state, halted = 1. The FSM stays in HALT until reset.
- Any other {opcode, op}, including an undefined branch op, goes to HALT.

## Timing
- Reset: on the edge where reset = 1, the state becomes RST. Outputs then read reset_pc = 1, load_pc = 1, and all others 0.
- Reset has priority over every state, including mid-instruction and HALT. A partially executed instruction is abandoned; registers already written stay written.
- The first IF1 is one cycle after reset deasserts.
- Cycles per instruction, counted IF1 to the next IF1:
  - MOV imm: 5.
  - MOV reg, MVN: 7.
  - ADD, AND: 8.
  - CMP: 7.
  - LDR: 8.
  - STR: 9.
  - Branch: 5, whether taken or not.
- Memory reads are synchronous with 1-cycle latency. mdata is valid during IF2 and LDR_WB, and the read command is held across both cycles of each pair.
- The PC is incremented in UPDATE_PC, so a branch offset is relative to PC+1.
- Flags are sampled in BRANCH only. They reflect the last CMP.

## Configuration
- CPU_CALL_EN defined: opcode 010 is decoded.
  - BL (op 11): BL_LINK (nsel = Rn, vsel = 1000, write), then BRANCH_TAKEN (load_pc, pc_sel = 01), then IF1. 6 cycles.
  - BX (op 00): BX_GET (nsel = Rd, loadb), then BX_C (asel = 1, csel = 1, loadc), then BX_PC (load_pc, pc_sel = 10), then IF1. 7 cycles.
  - BLX (op 10): BL_LINK, then BX_GET, BX_C, BX_PC, then IF1. 8 cycles.
- CPU_CALL_EN undefined: opcode 010 goes to HALT, and the BL/BX states do not exist.

## Test plan
- Reset, then MOV R0,#7 (opcode 110, op 10, sximm8 = 7) → state sequence RST, IF1, IF2, UPDATE_PC, DECODE, WRITE_IMM, IF1. write = 1 with vsel = 0100 for exactly one cycle.
- R1 = 3, R2 = 5; ADD R3,R1,R2 → 8 cycles. loada, loadb and loadc each pulse once, in that order. Writeback uses nsel = 010, and R3 = 8.
- CMP R1,R1, then BEQ +2 → loads pulses and loadc does not. In BRANCH, Z = 1 gives load_pc = 1 with pc_sel = 01, and the next fetch address is old PC + 3. Repeat with BNE: no load_pc in BRANCH.
- STR R0,[R1,#1] with R1 = 4, then LDR R2,[R1,#1] → mem_cmd = write with addr_sel = 0 for one cycle (address 5), then R2 = 7 after LDR_WB.
- Assert reset during GET_B of an ADD → next state RST, the destination register is not written, and fetch restarts at PC 0. Undefined opcode 000 → halted = 1, held for 20 cycles until reset.
- CPU_CALL_EN defined: BL +3 at PC 2 → R7 = 3 and next fetch at 6; BX R7 → next fetch at 3. With CPU_CALL_EN undefined, BL → halted = 1.
